// File: rtl/modport_counter.sv
// modport_counter: 4-bit up/down counter with parallel load (any load bit set wins over counting).
// Define COUNT_MOD12_EN to count modulo 12 instead of modulo 16.
module modport_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] din,
  input  logic [3:0] load,
  input  logic       up_down,
  output logic [3:0] count
);
  logic [3:0] next_count;
`ifdef COUNT_MOD12_EN
  // Out-of-range values (only reachable by loading 12..15 elsewhere) snap back on the next count.
  always_comb
    next_count = |load ? (din <= 4'd11 ? din : 4'd0)
               : up_down ? (count >= 4'd11 ? 4'd0 : count + 4'd1)
               : (count == 4'd0 || count > 4'd11 ? 4'd11 : count - 4'd1);
`else
  always_comb next_count = |load ? din : up_down ? count + 4'd1 : count - 4'd1;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) count <= 4'd0;
    else count <= next_count;
endmodule

// File: tb/tb_modport_counter.sv
// tb_modport_counter: directed self-checking bench for modport_counter.
module tb_modport_counter;
  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] din = 4'd0;
  logic [3:0] load = 4'd0;
  logic       up_down = 1'b1;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;

  modport_counter dut (
    .clock(clock),
    .resetn(resetn),
    .din(din),
    .load(load),
    .up_down(up_down),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_val(input logic [3:0] v);
    load = 4'b0001;
    din = v;
    step();
    load = 4'd0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_initial: count=%0d expected=0", count); end
    step();
    resetn = 1'b1;
    load = 4'b0010;
    din = 4'd9;
    step();
    load = 4'd0;
    checks++;
    if (count !== 4'd9) begin errors++; $display("FAIL reset_preload: count=%0d expected=9", count); end
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_async: count=%0d expected=0", count); end
    load = 4'b1111;
    din = 4'd5;
    up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL reset_hold%0d: count=%0d expected=0", i, count); end
    end
    resetn = 1'b1;
    load = 4'd0;
    step();
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL reset_release: count=%0d expected=1", count); end
  endtask

  task automatic test_load_priority();
    up_down = 1'b1;
    load = 4'b0100;
    din = 4'd7;
    step();
    load = 4'd0;
    checks++;
    if (count !== 4'd7) begin errors++; $display("FAIL load_priority_up: count=%0d expected=7", count); end
    up_down = 1'b0;
    load = 4'b1000;
    din = 4'd3;
    step();
    load = 4'd0;
    checks++;
    if (count !== 4'd3) begin errors++; $display("FAIL load_priority_down: count=%0d expected=3", count); end
  endtask

  task automatic test_direction();
    logic [3:0] e [4];
    logic       d [4];
    e = '{4'd6, 4'd7, 4'd6, 4'd5};
    d = '{1'b1, 1'b1, 1'b0, 1'b0};
    load_val(4'd5);
    for (int i = 0; i < 4; i++) begin
      up_down = d[i];
      step();
      checks++;
      if (count !== e[i]) begin errors++; $display("FAIL direction%0d: count=%0d expected=%0d", i, count, e[i]); end
    end
  endtask

`ifndef COUNT_MOD12_EN
  task automatic test_up_wrap();
    logic [3:0] e [3];
    e = '{4'd15, 4'd0, 4'd1};
    load_val(4'd14);
    up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== e[i]) begin errors++; $display("FAIL up_wrap%0d: count=%0d expected=%0d", i, count, e[i]); end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] e [3];
    e = '{4'd0, 4'd15, 4'd14};
    load_val(4'd1);
    up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== e[i]) begin errors++; $display("FAIL down_wrap%0d: count=%0d expected=%0d", i, count, e[i]); end
    end
  endtask
`else
  task automatic test_mod12();
    logic [3:0] e [3];
    e = '{4'd11, 4'd0, 4'd1};
    load_val(4'd10);
    checks++;
    if (count !== 4'd10) begin errors++; $display("FAIL mod12_load10: count=%0d expected=10", count); end
    up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== e[i]) begin errors++; $display("FAIL mod12_up%0d: count=%0d expected=%0d", i, count, e[i]); end
    end
    load_val(4'd13);
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL mod12_load13: count=%0d expected=0", count); end
    up_down = 1'b0;
    step();
    checks++;
    if (count !== 4'd11) begin errors++; $display("FAIL mod12_down_wrap: count=%0d expected=11", count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_priority();
    test_direction();
`ifndef COUNT_MOD12_EN
    test_up_wrap();
    test_down_wrap();
`else
    test_mod12();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modport_counter.md
MODPORT_COUNTER -- requirements
Module: modport_counter

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: din  input  4  parallel load data.
REQ-004 SHALL have port: load  input  4  load request vector; load active when any bit is 1 (load != 4'b0000).
REQ-005 SHALL have port: up_down  input  1  direction; 1 = count up, 0 = count down.
REQ-006 SHALL have port: count  output  4  registered counter value.
REQ-007 SHALL use one clock (clock) with asynchronous, active-low reset (resetn); polarity and synchronicity fixed.

Function
REQ-008 SHALL update count only on rising edge of clock while resetn = 1.
REQ-009 SHALL load count <= din on an edge where load != 0, regardless of up_down.
REQ-010 SHALL give load priority over counting when both apply in the same cycle.
REQ-011 SHALL increment count by 1 on an edge where load = 0 and up_down = 1.
REQ-012 SHALL decrement count by 1 on an edge where load = 0 and up_down = 0.
REQ-013 SHALL count every cycle with no separate enable; no hold state except during reset.
REQ-014 SHALL have latency of one edge: an input sampled at edge N is reflected in count immediately after edge N.
REQ-015 SHALL, in default build, wrap modulo 16: 15 + 1 -> 0; 0 - 1 -> 15.
REQ-016 SHALL drive count directly from a register, with no combinational path from inputs to count.
REQ-017 SHALL produce no X on count after reset, for any known input values.

Reset
REQ-018 SHALL force count to 4'b0000 asynchronously when resetn falls, without waiting for clock.
REQ-019 SHALL hold count at 0 while resetn = 0, ignoring load, din and up_down.
REQ-020 SHALL, on the first rising edge after resetn rises, apply the normal load/count rules starting from 0.
REQ-021 SHALL abandon any load or count in progress when reset is asserted mid-operation; no pending state survives reset.

Configuration
REQ-022 SHALL support macro COUNT_MOD12_EN; when undefined, behaviour is modulo-16 per REQ-015.
REQ-023 SHALL, with COUNT_MOD12_EN defined, count modulo 12: 11 + 1 -> 0; 0 - 1 -> 11.
REQ-024 SHALL, with COUNT_MOD12_EN defined, load din when din <= 11 and load 0 when din is 12..15.
REQ-025 SHALL, with COUNT_MOD12_EN defined, return count to range 0..11 on the next counting edge if it is ever outside that range: up -> 0, down -> 11.
REQ-026 SHALL leave reset value, load priority and latency identical in both builds.

Verification
REQ-027 SHALL cover reset: resetn = 0 asynchronously between edges with count = 9 -> count = 0 at once; count stays 0 while resetn is low.
REQ-028 SHALL cover load priority: load = 4'b0100, din = 7, up_down = 1 -> count = 7 after one edge, not an increment.
REQ-029 SHALL cover up wrap (default build): count = 14, load = 0, up_down = 1 for 3 edges -> 15, 0, 1.
REQ-030 SHALL cover down wrap (default build): count = 1, load = 0, up_down = 0 for 3 edges -> 0, 15, 14.
REQ-031 SHALL cover mod-12 build (COUNT_MOD12_EN): load din = 10, then up for 3 edges -> 10, 11, 0, 1; load din = 13 -> 0.
REQ-032 SHALL cover direction change: count = 5; up, up, down, down -> 6, 7, 6, 5.
